undo_encode: RTL and testbench

//  Transmit end of the undo-buffer serial link: queues trigger tags and serializes

---
 rtl/undo_link_pkg.sv | 25 ++
 rtl/undo_tag_fifo.sv | 51 +++++
 rtl/undo_encode.sv | 131 +++++++++++++
 tb/tb_undo_encode.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/undo_link_pkg.sv
// Shared definitions for the undo-buffer serial link.
// Used by the transmit side (undo_encode) and by receive-side checkers.
//  - FRAME_LEN : bits per frame (start, tag[1], tag[0], parity)
//  - START_BIT : level of the first frame bit
//  - undo_state_e : one-hot serializer states
//  - undo_parity : parity bit making start^t1^t0^p == 0
package undo_link_pkg;

  localparam int unsigned FRAME_LEN = 4;
  localparam logic        START_BIT = 1'b1;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_START = 6'b000010,
    ST_TB1   = 6'b000100,
    ST_TB0   = 6'b001000,
    ST_PAR   = 6'b010000,
    ST_GAP   = 6'b100000
  } undo_state_e;

  function automatic logic undo_parity(input logic [1:0] tag);
    return ~^tag;
  endfunction

endpackage

// File: rtl/undo_tag_fifo.sv
// Tag FIFO for the undo-link transmitter: DEPTH entries of 2-bit tags.
// Ports:
//  Clock, Reset  clock, asynchronous active-high reset
//  Push/PushData write request and tag (ignored while Full)
//  Pop/PopData   read request (ignored while Empty), head tag
//  Full, Empty   occupancy flags from pointer compare
module undo_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Push,
  input  logic [1:0] PushData,
  input  logic       Pop,
  output logic [1:0] PopData,
  output logic       Full,
  output logic       Empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [1:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_push = Push & ~Full;
  assign do_pop  = Pop & ~Empty;

  assign Empty   = (wr_ptr == rd_ptr);
  assign Full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign PopData = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= PushData;
  end

endmodule

// File: rtl/undo_encode.sv
// Transmit end of the undo-buffer serial link. Queues trigger tags and
// sends each as a 4-bit frame: start bit, Tag[1], Tag[0], parity.
// Ports:
//  Clock, Reset  100 MHz clock, asynchronous active-high reset
//  Request       1-clock strobe enqueuing TagIn
//  TagIn         trigger tag
//  Instance      board/link id (labels drop reports only)
//  UnDoBuf       registered serial output, low when not in a frame
//  Busy          frame in progress or FIFO non-empty
//  Full          FIFO full
//  Overflow      1-clock pulse when a Request is dropped
//  DropCnt       saturating dropped-request count
module undo_encode #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Request,
  input  logic [1:0] TagIn,
  input  logic [4:0] Instance,
  output logic       UnDoBuf,
  output logic       Busy,
  output logic       Full,
  output logic       Overflow,
  output logic [7:0] DropCnt
);

  import undo_link_pkg::*;

  localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  undo_state_e state;
  undo_state_e state_nxt;
  logic [1:0]  tag_reg;
  logic [1:0]  fifo_head;
  logic        fifo_empty;
  logic        pop;
  logic        bit_d;
  logic        line_q;
  logic [2:0]  gap_cnt;
  logic        drop;

  // Instance only labels drop reports in simulation; no hardware consumes it.
  logic unused_instance;
  assign unused_instance = ^Instance;

  // Full is sampled before this cycle's pop, so a request in a popping
  // cycle while Full is still dropped.
  assign drop = Request & Full;
  assign Busy = (state != ST_IDLE) | ~fifo_empty;

  undo_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .Push     (Request),
    .PushData (TagIn),
    .Pop      (pop),
    .PopData  (fifo_head),
    .Full     (Full),
    .Empty    (fifo_empty)
  );

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
      ST_START: state_nxt = ST_TB1;
      ST_TB1:   state_nxt = ST_TB0;
      ST_TB0:   state_nxt = ST_PAR;
      ST_PAR:   state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: FIFO pop and the frame bit for the current state
  always_comb begin
    pop   = 1'b0;
    bit_d = 1'b0;
    unique case (state)
      ST_IDLE:  pop   = ~fifo_empty;
      ST_START: bit_d = START_BIT;
      ST_TB1:   bit_d = tag_reg[1];
      ST_TB0:   bit_d = tag_reg[0];
      ST_PAR:   bit_d = undo_parity(tag_reg);
      default:  bit_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      gap_cnt <= '0;
      tag_reg <= '0;
    end else begin
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 3'd1 : 3'd0;
      if (pop) tag_reg <= fifo_head;
    end
  end

  // The frame bit passes through two flops so the start bit lands three
  // edges after the enqueue edge; every bit sees the same delay, so no bit
  // is stretched and reset still drops the line immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      line_q  <= 1'b0;
      UnDoBuf <= 1'b0;
    end else begin
      line_q  <= bit_d;
      UnDoBuf <= line_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Overflow <= 1'b0;
      DropCnt  <= '0;
    end else begin
      Overflow <= drop;
      if (drop && (DropCnt != 8'hFF)) DropCnt <= DropCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_undo_encode.sv
module tb_undo_encode;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Request, Request0;
  logic [1:0] TagIn, TagIn0;
  logic [4:0] Instance, Instance0;
  logic       UnDoBuf, Busy, Full, Overflow;
  logic       UnDoBuf0, Busy0, Full0, Overflow0;
  logic [7:0] DropCnt, DropCnt0;

  always #5 Clock = ~Clock;

  undo_encode #(.DEPTH(4), .GAP(1)) dut (
    .Clock(Clock), .Reset(Reset), .Request(Request), .TagIn(TagIn),
    .Instance(Instance), .UnDoBuf(UnDoBuf), .Busy(Busy), .Full(Full),
    .Overflow(Overflow), .DropCnt(DropCnt)
  );

  undo_encode #(.DEPTH(4), .GAP(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Request(Request0), .TagIn(TagIn0),
    .Instance(Instance0), .UnDoBuf(UnDoBuf0), .Busy(Busy0), .Full(Full0),
    .Overflow(Overflow0), .DropCnt(DropCnt0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Receiver model for each link: idle low, start bit 1, then t1, t0, p with
  // even overall parity; the cycle after a frame must be low.
  int         phase[2]    = '{0, 0};
  logic [2:0] sh[2]       = '{3'b0, 3'b0};
  logic       need_low[2] = '{1'b0, 1'b0};
  int         par_err[2]  = '{0, 0};
  int         gap_viol[2] = '{0, 0};
  logic [1:0] rxq0[$];
  logic [1:0] rxq1[$];

  task automatic rx_step(input int l, input logic b);
    if (Reset) begin
      phase[l]    = 0;
      need_low[l] = 1'b0;
    end else if (phase[l] == 0) begin
      if (need_low[l]) begin
        if (b) gap_viol[l]++;
        need_low[l] = 1'b0;
      end else if (b) begin
        phase[l] = 1;
      end
    end else begin
      sh[l] = {sh[l][1:0], b};
      phase[l]++;
      if (phase[l] == 4) begin
        phase[l]    = 0;
        need_low[l] = 1'b1;
        if ((1'b1 ^ sh[l][2] ^ sh[l][1] ^ sh[l][0]) != 1'b0) par_err[l]++;
        if (l == 0) rxq0.push_back(sh[l][2:1]);
        else        rxq1.push_back(sh[l][2:1]);
      end
    end
  endtask

  always begin
    @(posedge Clock);
    #2;
    rx_step(0, UnDoBuf);
    rx_step(1, UnDoBuf0);
  end

  task automatic wait_idle(input string name, input int l);
    int n;
    n = 0;
    while (((l == 1) ? (Busy0 || UnDoBuf0 || phase[1] != 0)
                     : (Busy || UnDoBuf || phase[0] != 0)) && n < 3000) begin
      tick();
      n++;
    end
    chk(name, (n >= 3000), 0);
    tick(); tick(); tick();
  endtask

  typedef struct {
    logic [1:0] tag;
    logic [3:0] frame;
  } vec_t;

  vec_t vecs[4];
  logic [3:0] bb_frames[3];
  logic [1:0] ovf_tags[8];
  logic [1:0] ovf_sent[5];
  logic [1:0] sent1[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs = '{'{2'b00, 4'b1001}, '{2'b01, 4'b1010}, '{2'b10, 4'b1100}, '{2'b11, 4'b1111}};
    bb_frames = '{4'b1001, 4'b1010, 4'b1111};
    ovf_tags  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ovf_sent  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    Reset = 1'b0; Request = 1'b0; TagIn = 2'b00; Request0 = 1'b0; TagIn0 = 2'b00;
    Instance = 5'd3; Instance0 = 5'd4;
    #2 Reset = 1'b1;
    tick(); tick();
    chk("rst_undobuf", UnDoBuf, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_full", Full, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_dropcnt", DropCnt, 0);
    chk("rst_busy0", Busy0, 0);
    Reset = 1'b0;
    tick();

    // Single frames on an idle link, one table entry per tag
    for (int i = 0; i < 4; i++) begin
      logic [3:0] fr;
      fr = vecs[i].frame;
      Request = 1'b1; TagIn = vecs[i].tag;
      tick();
      Request = 1'b0;
      chk("single_busy", Busy, 1);
      for (int k = 1; k <= 7; k++) begin
        tick();
        chk("single_bit", UnDoBuf, (k >= 3 && k <= 6) ? fr[6-k] : 1'b0);
      end
      chk("single_idle", Busy, 0);
      tick();
    end
    wait_idle("single_drain", 0);
    chk("single_rx_count", rxq0.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rxq0.size()) chk("single_rx_tag", rxq0[i], vecs[i].tag);
    rxq0.delete();

    // Back-to-back: tags 00, 01, 11 on consecutive edges, 6-cycle frame period
    Request = 1'b1; TagIn = 2'b00; tick();
    TagIn = 2'b01; tick();
    TagIn = 2'b11; tick();
    Request = 1'b0;
    for (int k = 3; k <= 20; k++) begin
      int f, off;
      logic [3:0] fr;
      logic e;
      tick();
      f = (k - 3) / 6;
      off = (k - 3) % 6;
      e = 1'b0;
      if (f < 3 && off < 4) begin
        fr = bb_frames[f];
        e = fr[3-off];
      end
      chk("b2b_bit", UnDoBuf, e);
    end
    wait_idle("b2b_drain", 0);
    chk("b2b_rx_count", rxq0.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < rxq0.size()) chk("b2b_rx_tag", rxq0[i], (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b11);
    rxq0.delete();

    // Overflow: 8 requests on consecutive edges; drops at edges n+5..n+7,
    // the last coinciding with the FSM pop
    for (int j = 0; j < 8; j++) begin
      Request = 1'b1; TagIn = ovf_tags[j];
      tick();
      chk("ovf_full", Full, (j >= 4 && j <= 6) ? 1'b1 : 1'b0);
      chk("ovf_pulse", Overflow, (j >= 5) ? 1'b1 : 1'b0);
    end
    Request = 1'b0;
    tick();
    chk("ovf_pulse_end", Overflow, 0);
    chk("ovf_dropcnt", DropCnt, 3);
    wait_idle("ovf_drain", 0);
    chk("ovf_rx_count", rxq0.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rxq0.size()) chk("ovf_rx_order", rxq0[i], ovf_sent[i]);
    rxq0.delete();

    // Reset during Tb0 truncates the frame and clears everything
    Request = 1'b1; TagIn = 2'b11;
    tick();
    Request = 1'b0;
    tick(); tick(); tick();
    chk("rstmid_start_bit", UnDoBuf, 1);
    Reset = 1'b1;
    #1;
    chk("rstmid_line_low", UnDoBuf, 0);
    chk("rstmid_busy", Busy, 0);
    chk("rstmid_full", Full, 0);
    chk("rstmid_dropcnt", DropCnt, 0);
    tick();
    Reset = 1'b0;
    tick();
    rxq0.delete();
    Request = 1'b1; TagIn = 2'b10;
    tick();
    Request = 1'b0;
    wait_idle("rstmid_drain", 0);
    chk("rstmid_rx_count", rxq0.size(), 1);
    if (rxq0.size() > 0) chk("rstmid_rx_tag", rxq0[0], 2'b10);
    rxq0.delete();

    // DropCnt saturation under sustained requests
    Request = 1'b1; TagIn = 2'b01;
    for (int j = 0; j < 400; j++) tick();
    Request = 1'b0;
    chk("sat_dropcnt", DropCnt, 8'hFF);
    tick();
    chk("sat_pulse_end", Overflow, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    rxq0.delete();

    // GAP=0 sweep: 256 random tags, pushed only when not Full
    begin
      int i, cyc, mism;
      i = 0; cyc = 0; mism = 0;
      while (i < 256 && cyc < 5000) begin
        if (!Full0) begin
          Request0 = 1'b1;
          TagIn0 = 2'($urandom_range(0, 3));
          sent1.push_back(TagIn0);
          i++;
        end else begin
          Request0 = 1'b0;
        end
        tick();
        cyc++;
      end
      Request0 = 1'b0;
      chk("sweep_sent", i, 256);
      wait_idle("sweep_drain", 1);
      chk("sweep_rx_count", rxq1.size(), 256);
      for (int k = 0; k < 256; k++)
        if (k < rxq1.size() && k < sent1.size() && rxq1[k] != sent1[k]) mism++;
      chk("sweep_tag_mismatches", mism, 0);
      chk("sweep_dropcnt", DropCnt0, 0);
    end

    chk("parity_errors_link0", par_err[0], 0);
    chk("parity_errors_link1", par_err[1], 0);
    chk("gap_violations_link0", gap_viol[0], 0);
    chk("gap_violations_link1", gap_viol[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
